sm_run_ctrl: RTL and testbench
==============================

Name: sm_run_ctrl

Overview:
Run-control sequencer for the single-cycle schoolMIPS core. It produces the core's clock-enable `cpuEn` and uses it to halt, run, single-step or N-step the CPU on host command. It stops execution at a PC breakpoint and counts cycles and retired instructions. It sits between the board debug interface (buttons/UART command decoder) and the CPU, watching the CPU's `imAddr`.

Parameters:
ADDR_WIDTH, 32, width of `pc` and `bpAddr`
CNT_WIDTH, 32, width of `cycleCnt` and `instrCnt`
STEP_WIDTH, 16, width of the step-count argument

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
cmdValid  input  1  one-cycle command strobe
cmdOp  input  2  00 HALT, 01 RUN, 10 STEP, 11 CLR_CNT
cmdArg  input  STEP_WIDTH  step count for STEP (0 treated as 1)
bpEnable  input  1  breakpoint enable
bpAddr  input  ADDR_WIDTH  breakpoint word address
pc  input  ADDR_WIDTH  current CPU instruction address (`imAddr`)
cpuEn  output  1  CPU clock enable; 1 = the CPU retires one instruction this cycle
halted  output  1  1 when state is HALT
haltCause  output  2  00 reset, 01 host HALT, 10 breakpoint, 11 step done
cmdErr  output  1  one-cycle pulse: command rejected
cycleCnt  output  CNT_WIDTH  clocks since last clear
instrCnt  output  CNT_WIDTH  instructions retired (cpuEn cycles) since last clear

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - state=HALT, cpuEn=0, halted=1, haltCause=00, cmdErr=0
  - cycleCnt=0, instrCnt=0, stepRem=0, bpArmed=0
- States: HALT, RUN, STEP. All transitions are on the clk rising edge.
- cpuEn is combinational: (state==RUN && !bpHit) || state==STEP.
- bpHit = bpEnable && bpArmed && (pc==bpAddr). This is a combinational path from `pc`, so a breakpoint stops the core before the matching instruction executes.
- bpArmed:
  - Cleared on every entry to RUN.
  - Set after the first cpuEn cycle in RUN.
  - Effect: resuming from a breakpoint address executes that instruction instead of re-halting.
- HALT:
  - cmdValid & RUN -> RUN.
  - cmdValid & STEP -> STEP; stepRem = (cmdArg==0) ? 1 : cmdArg.
  - HALT command -> stays in HALT; haltCause=01.
- RUN:
  - bpHit -> HALT with haltCause=10; cpuEn=0 in that cycle.
  - cmdValid & HALT -> HALT with haltCause=01. The instruction in the command cycle still retires (cpuEn=1 that cycle unless bpHit).
  - bpHit and a HALT command in the same cycle -> haltCause=10.
- STEP:
  - Breakpoints are ignored.
  - stepRem decrements on each cpuEn cycle.
  - When stepRem==1 -> HALT with haltCause=11. Exactly cmdArg instructions retire.
  - cmdValid & HALT -> HALT with haltCause=01 after the current instruction retires.
- Command rejection:
  - RUN or STEP issued while in RUN or STEP is ignored and pulses cmdErr for one cycle.
  - CLR_CNT is accepted in every state.
- Counters:
  - cycleCnt increments every clock.
  - instrCnt increments when cpuEn=1.
  - Both wrap modulo 2^CNT_WIDTH.
  - CLR_CNT forces both to 0 on the next edge; clear wins over a same-cycle increment.
- halted is registered: it equals (state==HALT).
- Reset mid-RUN or mid-STEP: cpuEn drops immediately (async), state returns to HALT, and the pending stepRem is discarded.

Test Plan:
- Reset release, no commands -> halted=1, haltCause=00, cpuEn=0. After 10 clocks: cycleCnt=10, instrCnt=0.
- From HALT, STEP with cmdArg=3 -> cpuEn high for exactly 3 cycles, then halted=1, haltCause=11, instrCnt=3. STEP with cmdArg=0 -> exactly 1 cycle.
- RUN with bpEnable=1, bpAddr=5, pc advancing 0,1,2,... -> cpuEn drops in the cycle pc==5, halted=1, haltCause=10, instrCnt=5. A following RUN retires pc=5 (no re-halt) and continues.
- RUN, then HALT command after 7 cpuEn cycles -> instrCnt=8 (command cycle retires), haltCause=01. A STEP issued during RUN -> cmdErr pulses once and the state is unchanged.
- CLR_CNT at cycleCnt=0xFFFFFFFF while running -> both counters read 0 next cycle. Without the clear, cycleCnt wraps to 0.
- Assert rst mid-STEP (stepRem=4) -> cpuEn=0 immediately. After release: HALT, haltCause=00, and a new STEP with cmdArg=1 retires exactly 1 instruction.

Source files
------------

// File: rtl/sm_run_ctrl.sv
`timescale 1ns/1ps
// sm_run_ctrl: run-control sequencer for the single-cycle schoolMIPS core.
// Produces the CPU clock-enable and uses it to halt, run, single-step or N-step
// the core on host command. It stops at a PC breakpoint and counts cycles and
// retired instructions.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   cmdValid/cmdOp     one-cycle command strobe and opcode
//                      (00 HALT, 01 RUN, 10 STEP, 11 CLR_CNT)
//   cmdArg             STEP count (0 behaves as 1)
//   bpEnable/bpAddr    breakpoint enable and word address
//   pc                 current CPU instruction address (imAddr)
//   cpuEn              combinational CPU clock enable (1 = retire this cycle)
//   halted             registered, 1 while in HALT
//   haltCause          00 reset, 01 host HALT, 10 breakpoint, 11 step done
//   cmdErr             one-cycle pulse when RUN/STEP is rejected
//   cycleCnt/instrCnt  clocks / retired instructions since last clear
module sm_run_ctrl #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned STEP_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmdValid,
  input  logic [1:0]            cmdOp,
  input  logic [STEP_WIDTH-1:0] cmdArg,
  input  logic                  bpEnable,
  input  logic [ADDR_WIDTH-1:0] bpAddr,
  input  logic [ADDR_WIDTH-1:0] pc,
  output logic                  cpuEn,
  output logic                  halted,
  output logic [1:0]            haltCause,
  output logic                  cmdErr,
  output logic [CNT_WIDTH-1:0]  cycleCnt,
  output logic [CNT_WIDTH-1:0]  instrCnt
);

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_e;

  localparam logic [1:0] OP_HALT = 2'b00;
  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  localparam logic [1:0] CAUSE_RESET = 2'b00;
  localparam logic [1:0] CAUSE_HOST  = 2'b01;
  localparam logic [1:0] CAUSE_BP    = 2'b10;
  localparam logic [1:0] CAUSE_STEP  = 2'b11;

  state_e                state_q, state_d;
  logic [STEP_WIDTH-1:0] step_rem_q, step_rem_d;
  logic                  bp_armed_q, bp_armed_d;
  logic [1:0]            halt_cause_q, halt_cause_d;
  logic                  cmd_err_q, cmd_err_d;
  logic                  halted_q, halted_d;
  logic [CNT_WIDTH-1:0]  cycle_cnt_q, cycle_cnt_d;
  logic [CNT_WIDTH-1:0]  instr_cnt_q, instr_cnt_d;

  logic cmd_halt, cmd_run, cmd_step, cmd_clr;
  logic bp_hit, cpu_en;

  // Command decode
  assign cmd_halt = cmdValid && (cmdOp == OP_HALT);
  assign cmd_run  = cmdValid && (cmdOp == OP_RUN);
  assign cmd_step = cmdValid && (cmdOp == OP_STEP);
  assign cmd_clr  = cmdValid && (cmdOp == OP_CLR);

  // Breakpoint compare is combinational from pc so the matching instruction
  // never retires; the armed flag lets a resume execute the breakpoint address.
  assign bp_hit = bpEnable && bp_armed_q && (pc == bpAddr);
  assign cpu_en = ((state_q == ST_RUN) && !bp_hit) || (state_q == ST_STEP);

  // Next-state and register-input logic
  always_comb begin
    state_d      = state_q;
    step_rem_d   = step_rem_q;
    bp_armed_d   = bp_armed_q;
    halt_cause_d = halt_cause_q;
    cmd_err_d    = 1'b0;

    unique case (state_q)
      ST_HALT: begin
        if (cmd_run) begin
          state_d    = ST_RUN;
          bp_armed_d = 1'b0;
        end else if (cmd_step) begin
          state_d    = ST_STEP;
          step_rem_d = (cmdArg == '0) ? STEP_WIDTH'(1) : cmdArg;
        end else if (cmd_halt) begin
          halt_cause_d = CAUSE_HOST;
        end
      end

      ST_RUN: begin
        cmd_err_d = cmd_run || cmd_step;
        // Breakpoint outranks a same-cycle host HALT.
        if (bp_hit) begin
          state_d      = ST_HALT;
          halt_cause_d = CAUSE_BP;
        end else if (cmd_halt) begin
          state_d      = ST_HALT;
          halt_cause_d = CAUSE_HOST;
        end else begin
          bp_armed_d = 1'b1;
        end
      end

      ST_STEP: begin
        cmd_err_d  = cmd_run || cmd_step;
        step_rem_d = step_rem_q - STEP_WIDTH'(1);
        if (cmd_halt) begin
          state_d      = ST_HALT;
          halt_cause_d = CAUSE_HOST;
        end else if (step_rem_q <= STEP_WIDTH'(1)) begin
          state_d      = ST_HALT;
          halt_cause_d = CAUSE_STEP;
        end
      end

      default: begin
        state_d = ST_HALT;
      end
    endcase

    halted_d = (state_d == ST_HALT);

    // Clear wins over the same-cycle increment.
    if (cmd_clr) begin
      cycle_cnt_d = '0;
      instr_cnt_d = '0;
    end else begin
      cycle_cnt_d = cycle_cnt_q + CNT_WIDTH'(1);
      instr_cnt_d = instr_cnt_q + CNT_WIDTH'(cpu_en);
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_HALT;
      step_rem_q   <= '0;
      bp_armed_q   <= 1'b0;
      halt_cause_q <= CAUSE_RESET;
      cmd_err_q    <= 1'b0;
      halted_q     <= 1'b1;
      cycle_cnt_q  <= '0;
      instr_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      step_rem_q   <= step_rem_d;
      bp_armed_q   <= bp_armed_d;
      halt_cause_q <= halt_cause_d;
      cmd_err_q    <= cmd_err_d;
      halted_q     <= halted_d;
      cycle_cnt_q  <= cycle_cnt_d;
      instr_cnt_q  <= instr_cnt_d;
    end
  end

  assign cpuEn     = cpu_en;
  assign halted    = halted_q;
  assign haltCause = halt_cause_q;
  assign cmdErr    = cmd_err_q;
  assign cycleCnt  = cycle_cnt_q;
  assign instrCnt  = instr_cnt_q;

endmodule

// File: tb/tb_sm_run_ctrl.sv
`timescale 1ns/1ps
// Bench for sm_run_ctrl: directed test-plan steps plus a random command phase,
// all checked every cycle against a behavioural model of the run controller.
// Counters are built 8 bits wide so wrap-around is reachable.
module tb_sm_run_ctrl;

  localparam int unsigned AW = 32;
  localparam int unsigned CW = 8;
  localparam int unsigned SW = 16;

  localparam logic [1:0] OP_HALT = 2'b00;
  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  localparam int M_HALT = 0;
  localparam int M_RUN  = 1;
  localparam int M_STEP = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmdValid = 1'b0;
  logic [1:0]    cmdOp = 2'b00;
  logic [SW-1:0] cmdArg = '0;
  logic          bpEnable = 1'b0;
  logic [AW-1:0] bpAddr = '0;
  logic [AW-1:0] pc = '0;
  logic          cpuEn;
  logic          halted;
  logic [1:0]    haltCause;
  logic          cmdErr;
  logic [CW-1:0] cycleCnt;
  logic [CW-1:0] instrCnt;

  sm_run_ctrl #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW), .STEP_WIDTH(SW)) dut (
    .clk(clk), .rst(rst), .cmdValid(cmdValid), .cmdOp(cmdOp), .cmdArg(cmdArg),
    .bpEnable(bpEnable), .bpAddr(bpAddr), .pc(pc), .cpuEn(cpuEn),
    .halted(halted), .haltCause(haltCause), .cmdErr(cmdErr),
    .cycleCnt(cycleCnt), .instrCnt(instrCnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int seen_en = 0;

  // Model of the controller: mode, instructions left in a step burst, whether
  // a breakpoint may fire yet, last halt reason, and the two counters.
  int            m_mode;
  int            m_left;
  bit            m_armed;
  logic [1:0]    m_cause;
  bit            m_err;
  logic [CW-1:0] m_cyc;
  logic [CW-1:0] m_ins;

  // Stimulus-side CPU: pc advances whenever an instruction retires.
  logic [AW-1:0] pc_v = '0;
  bit            bp_en_v = 1'b0;
  logic [AW-1:0] bp_addr_v = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = M_HALT;
    m_left  = 0;
    m_armed = 1'b0;
    m_cause = 2'b00;
    m_err   = 1'b0;
    m_cyc   = '0;
    m_ins   = '0;
  endtask

  function automatic bit model_retires();
    bit stop_here;
    stop_here = bp_en_v && m_armed && (pc_v == bp_addr_v);
    return (m_mode == M_STEP) || (m_mode == M_RUN && !stop_here);
  endfunction

  // One clock: drive at negedge, check, then advance the model at the posedge.
  task automatic cycle(input bit v, input logic [1:0] op, input logic [SW-1:0] arg);
    bit en;
    bit at_bp;
    @(negedge clk);
    cmdValid = v;
    cmdOp    = op;
    cmdArg   = arg;
    pc       = pc_v;
    bpEnable = bp_en_v;
    bpAddr   = bp_addr_v;
    #1;
    en    = model_retires();
    at_bp = bp_en_v && m_armed && (pc_v == bp_addr_v);
    check("cpuEn", 32'(cpuEn), 32'(en));
    check("halted", 32'(halted), 32'(m_mode == M_HALT));
    check("haltCause", 32'(haltCause), 32'(m_cause));
    check("cmdErr", 32'(cmdErr), 32'(m_err));
    check("cycleCnt", 32'(cycleCnt), 32'(m_cyc));
    check("instrCnt", 32'(instrCnt), 32'(m_ins));
    if (cpuEn === 1'b1) seen_en++;
    @(posedge clk);
    if (v && op == OP_CLR) begin
      m_cyc = '0;
      m_ins = '0;
    end else begin
      m_cyc = CW'(m_cyc + 1);
      m_ins = CW'(m_ins + CW'(en));
    end
    m_err = v && (op == OP_RUN || op == OP_STEP) && (m_mode != M_HALT);
    if (m_mode == M_HALT) begin
      if (v && op == OP_RUN) begin
        m_mode  = M_RUN;
        m_armed = 1'b0;
      end else if (v && op == OP_STEP) begin
        m_mode = M_STEP;
        m_left = (arg == 0) ? 1 : int'(arg);
      end else if (v && op == OP_HALT) begin
        m_cause = 2'b01;
      end
    end else if (m_mode == M_RUN) begin
      if (at_bp) begin
        m_mode  = M_HALT;
        m_cause = 2'b10;
      end else if (v && op == OP_HALT) begin
        m_mode  = M_HALT;
        m_cause = 2'b01;
      end else begin
        m_armed = 1'b1;
      end
    end else begin
      m_left--;
      if (v && op == OP_HALT) begin
        m_mode  = M_HALT;
        m_cause = 2'b01;
      end else if (m_left == 0) begin
        m_mode  = M_HALT;
        m_cause = 2'b11;
      end
    end
    if (en) pc_v = pc_v + 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, OP_HALT, '0);
  endtask

  initial begin
    bit            rv;
    logic [1:0]    rop;
    logic [SW-1:0] rarg;

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_halted", 32'(halted), 32'd1);
    check("rst_cause", 32'(haltCause), 32'd0);
    check("rst_cpuEn", 32'(cpuEn), 32'd0);
    rst = 1'b0;

    // Idle after reset
    idle(10);
    #2;
    check("idle_cycleCnt", 32'(cycleCnt), 32'd10);
    check("idle_instrCnt", 32'(instrCnt), 32'd0);

    // STEP 3 then STEP 0
    seen_en = 0;
    cycle(1'b1, OP_STEP, 16'd3);
    idle(5);
    #2;
    check("step3_count", 32'(seen_en), 32'd3);
    check("step3_halted", 32'(halted), 32'd1);
    check("step3_cause", 32'(haltCause), 32'd3);
    check("step3_instr", 32'(instrCnt), 32'd3);
    seen_en = 0;
    cycle(1'b1, OP_STEP, 16'd0);
    idle(3);
    #2;
    check("step0_count", 32'(seen_en), 32'd1);
    check("step0_instr", 32'(instrCnt), 32'd4);

    // Breakpoint at 5 with pc advancing from 0
    pc_v = '0;
    bp_en_v = 1'b1;
    bp_addr_v = 32'd5;
    cycle(1'b1, OP_CLR, '0);
    cycle(1'b1, OP_RUN, '0);
    idle(6);
    #2;
    check("bp_halted", 32'(halted), 32'd1);
    check("bp_cause", 32'(haltCause), 32'd2);
    check("bp_instr", 32'(instrCnt), 32'd5);
    cycle(1'b1, OP_RUN, '0);
    idle(4);
    #2;
    check("bp_resume_running", 32'(halted), 32'd0);
    check("bp_resume_instr", 32'(instrCnt), 32'd9);
    cycle(1'b1, OP_HALT, '0);
    bp_en_v = 1'b0;

    // Host HALT after 7 retired instructions
    cycle(1'b1, OP_CLR, '0);
    cycle(1'b1, OP_RUN, '0);
    idle(7);
    cycle(1'b1, OP_HALT, '0);
    #2;
    check("hh_instr", 32'(instrCnt), 32'd8);
    check("hh_cause", 32'(haltCause), 32'd1);

    // STEP rejected while running
    cycle(1'b1, OP_RUN, '0);
    idle(2);
    cycle(1'b1, OP_STEP, 16'd2);
    #2;
    check("err_pulse", 32'(cmdErr), 32'd1);
    check("err_still_run", 32'(halted), 32'd0);
    idle(1);
    #2;
    check("err_one_cycle", 32'(cmdErr), 32'd0);
    cycle(1'b1, OP_HALT, '0);

    // Random command phase
    for (int i = 0; i < 600; i++) begin
      rv   = ($urandom_range(0, 5) == 0);
      rop  = 2'($urandom_range(0, 3));
      rarg = SW'($urandom_range(0, 4));
      if (rv && rop == OP_HALT && m_mode == M_STEP && m_left == 1) rv = 1'b0;
      if ($urandom_range(0, 7) == 0) pc_v = AW'($urandom_range(0, 15));
      if ($urandom_range(0, 31) == 0) begin
        bp_en_v   = 1'($urandom_range(0, 1));
        bp_addr_v = AW'($urandom_range(0, 15));
      end
      cycle(rv, rop, rarg);
    end

    // Settle into HALT, then counter clear and wrap while running
    bp_en_v = 1'b0;
    for (int i = 0; i < 20 && m_mode != M_HALT; i++) idle(1);
    cycle(1'b1, OP_RUN, '0);
    for (int i = 0; i < 300 && m_cyc != 8'hFF; i++) idle(1);
    cycle(1'b1, OP_CLR, '0);
    #2;
    check("clr_cycle", 32'(cycleCnt), 32'd0);
    check("clr_instr", 32'(instrCnt), 32'd0);
    for (int i = 0; i < 300 && m_cyc != 8'hFF; i++) idle(1);
    idle(1);
    #2;
    check("wrap_cycle", 32'(cycleCnt), 32'd0);
    cycle(1'b1, OP_HALT, '0);

    // Reset in the middle of a step burst
    cycle(1'b1, OP_STEP, 16'd6);
    idle(2);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_cpuEn", 32'(cpuEn), 32'd0);
    check("rst_mid_halted", 32'(halted), 32'd1);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);
    #2;
    check("post_rst_cause", 32'(haltCause), 32'd0);
    seen_en = 0;
    cycle(1'b1, OP_STEP, 16'd1);
    idle(3);
    #2;
    check("post_rst_step_count", 32'(seen_en), 32'd1);
    check("post_rst_step_cause", 32'(haltCause), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
